// File: rtl/vdma_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vdma_burst_arbiter
// Purpose  : Round-robin scheduler sharing one AXI master command port among
//            NCH FIFO status controllers. One transaction outstanding at a
//            time; per-channel fsync suppresses resp/done to the requester
//            without ever dropping cmd_valid before cmd_ready.
// Revision : 1.0 - initial release
// ============================================================================
module vdma_burst_arbiter #(
  parameter  int NCH   = 2,
  parameter  int LSIZE = 9,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NCH-1:0]       req_burst,
  input  logic [NCH-1:0]       req_tail,
  input  logic [NCH*LSIZE-1:0] req_len,
  input  logic [NCH-1:0]       fsync,
  output logic [NCH-1:0]       resp,
  output logic [NCH-1:0]       done,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [CW-1:0]        cmd_ch,
  output logic [LSIZE-1:0]     cmd_len,
  output logic                 cmd_tail,
  input  logic                 xfer_done,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_last_grant;
  logic [CW-1:0]    r_cmd_ch;
  logic [LSIZE-1:0] r_cmd_len;
  logic             r_cmd_tail;
  logic             r_cmd_valid;
  logic             r_busy;
  logic             r_abort;
  logic [NCH-1:0]   r_resp;
  logic [NCH-1:0]   r_done;

  logic [NCH-1:0]   w_req;
  logic [CW:0]      w_pick;
  logic             w_found;
  logic [CW-1:0]    w_gnt;
  logic             w_grant;
  logic             w_abort_now;

  // Circular search starting just after the last grant; the nearest hit wins
  // because the loop walks from the farthest candidate towards the nearest.
  function automatic logic [CW:0] f_pick(input logic [NCH-1:0] req,
                                         input logic [CW-1:0]  last);
    logic [CW:0] res;
    int          idx;
    res = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = (int'(last) + k) % NCH;
      if (req[idx]) res = {1'b1, CW'(idx)};
    end
    return res;
  endfunction

  // A channel asserting fsync in the grant cycle is not eligible.
  assign w_req   = (req_burst | req_tail) & ~fsync;
  assign w_pick  = f_pick(w_req, r_last_grant);
  assign w_found = w_pick[CW];
  assign w_gnt   = w_pick[CW-1:0];

  // Abort seen this cycle, including an fsync coinciding with the event.
  assign w_abort_now = r_abort | ((r_state != S_IDLE) && fsync[r_cmd_ch]);

  // State register.
  always_ff @(posedge clock) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic and grant decision.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && w_found) begin
          w_state_next = S_ISSUE;
          w_grant      = 1'b1;
        end
      end
      S_ISSUE: begin
        // xfer_done in the handshake cycle is ignored by construction.
        if (cmd_ready) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (xfer_done) w_state_next = S_RELEASE;
      end
      S_RELEASE: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Registered command, pulses and bookkeeping, all derived from the next state.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_last_grant <= CW'(NCH - 1);
      r_cmd_ch     <= '0;
      r_cmd_len    <= '0;
      r_cmd_tail   <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_abort      <= 1'b0;
      r_resp       <= '0;
      r_done       <= '0;
    end else begin
      r_cmd_valid <= (w_state_next == S_ISSUE);
      r_busy      <= (w_state_next != S_IDLE);
      r_resp      <= '0;
      r_done      <= '0;
      if (w_grant) begin
        r_cmd_ch     <= w_gnt;
        r_cmd_len    <= req_len[w_gnt*LSIZE +: LSIZE];
        r_cmd_tail   <= req_tail[w_gnt];
        r_last_grant <= w_gnt;
        r_abort      <= 1'b0;
      end else begin
        r_abort <= w_abort_now;
      end
      if ((r_state == S_ISSUE) && cmd_ready && !w_abort_now) r_resp[r_cmd_ch] <= 1'b1;
      if ((r_state == S_WAIT) && xfer_done && !w_abort_now)  r_done[r_cmd_ch] <= 1'b1;
    end
  end

  assign resp      = r_resp;
  assign done      = r_done;
  assign cmd_valid = r_cmd_valid;
  assign cmd_ch    = r_cmd_ch;
  assign cmd_len   = r_cmd_len;
  assign cmd_tail  = r_cmd_tail;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/vdma_burst_arbiter.md
# vdma_burst_arbiter

Round-robin scheduler that shares one AXI master command port among NCH FIFO status controllers (read or write side of the VDMA). Each controller raises a level burst or tail request with a length. The arbiter grants one requester at a time and forwards the command to the AXI master. It returns a one-cycle resp pulse when the command is accepted and a one-cycle done pulse when the data phase completes. Only one transaction is outstanding at a time; a per-channel fsync aborts the handshake back to its requester without violating the AXI valid/ready rule.

## Interface
- NCH, 2, number of requesting channels (1..8)
- LSIZE, 9, width of burst length fields
- CW, $clog2(NCH) with minimum 1, channel index width (derived localparam)
- clock  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- enable  in  1  when low, no new grant is made; an in-flight transaction completes normally
- req_burst  in  NCH  level burst request per channel, held until resp
- req_tail  in  NCH  level tail request per channel, held until resp
- req_len  in  NCH*LSIZE  channel i length at [i*LSIZE +: LSIZE]
- fsync  in  NCH  per-channel frame sync / abort
- resp  out  NCH  one-cycle pulse to granted channel when command is accepted
- done  out  NCH  one-cycle pulse to granted channel when transfer completes
- cmd_valid  out  1  command valid to AXI master
- cmd_ready  in  1  command accepted by AXI master
- cmd_ch  out  CW  granted channel index
- cmd_len  out  LSIZE  granted length
- cmd_tail  out  1  command is a tail transfer
- xfer_done  in  1  one-cycle pulse from AXI master at end of data phase
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT_XFER, RELEASE.
- Request vector: req[i] = req_burst[i] | req_tail[i].
- IDLE
  - If enable and req is nonzero, grant the first channel with req set, searching circularly from last_grant+1.
  - On grant: register cmd_ch, cmd_len = req_len slice, cmd_tail = req_tail[g]. If both request bits are set, tail wins.
  - Clear the abort flag, update last_grant, go to ISSUE.
  - A channel whose fsync is high in the grant cycle is excluded from the search that cycle.
- ISSUE
  - cmd_valid = 1. cmd_ch, cmd_len and cmd_tail stay stable.
  - On cmd_ready: pulse resp[cmd_ch] unless abort is set, then go to WAIT_XFER.
- WAIT_XFER
  - On xfer_done, go to RELEASE.
- RELEASE
  - Pulse done[cmd_ch] unless abort is set, then go to IDLE.
- Abort
  - fsync[cmd_ch] high in ISSUE, WAIT_XFER or RELEASE sets abort, which is sticky until the next grant.
  - cmd_valid is never dropped before cmd_ready. An aborted transaction still runs to xfer_done; only resp and done to the requester are suppressed.
  - fsync on a non-granted channel has no effect on the current transaction.
- Simultaneous events
  - cmd_ready and xfer_done in the same ISSUE cycle: the xfer_done is ignored. The master guarantees xfer_done comes at least one cycle after cmd_ready.
  - fsync and cmd_ready in the same cycle: resp is suppressed.
- Round-robin fairness: a continuously requesting channel waits at most NCH-1 other transactions.
- last_grant resets to NCH-1, so channel 0 has first priority after reset.

## Timing
- All outputs are registered.
- Reset values:
  - State: IDLE.
  - cmd_valid, busy, resp, done, cmd_tail, abort: 0.
  - cmd_ch, cmd_len: 0.
  - last_grant: NCH-1.
- Reset mid-operation returns to IDLE in one cycle and drops cmd_valid. The AXI master is reset by the same rst_n.
- Grant latency: request sampled in IDLE at cycle t, so cmd_valid = 1 at t+1.
- resp[g] is high in the cycle after the cmd_ready handshake and lasts exactly one cycle.
- done[g] is high in the cycle after xfer_done, in RELEASE, and lasts exactly one cycle.
- Minimum gap between grants is one IDLE cycle. This lets the requester drop its level request after resp, before re-arbitration.
- Throughput: at most one transaction per (4 + ready wait + data wait) cycles.

## Test plan
- Single request: NCH=2, req_burst[0]=1, len=100, cmd_ready 3 cycles later, xfer_done 20 cycles later.
  - Required: cmd_valid at t+1 with cmd_ch=0, cmd_len=100, cmd_tail=0.
  - Required: resp[0] one pulse, then done[0] one pulse one cycle after xfer_done; busy low afterwards.
- Round-robin: both channels requesting continuously for 6 transactions.
  - Required: cmd_ch sequence 0,1,0,1,0,1.
  - Required: each requester gets resp and done only on its own transactions.
- Tail path: req_tail[1]=1 with req_len slice 37.
  - Required: cmd_ch=1, cmd_tail=1, cmd_len=37, followed by resp[1] and done[1].
- Abort in WAIT_XFER: fsync[0] pulsed after resp[0].
  - Required: transaction still waits for xfer_done; done[0] is never asserted; the next grant proceeds normally.
- Abort in ISSUE with cmd_ready held low for 5 cycles and fsync[0] in cycle 2.
  - Required: cmd_valid stays high until cmd_ready; no resp[0] and no done[0].
- enable low with requests pending.
  - Required: no cmd_valid.
  - Required: deassert enable during WAIT_XFER; the transfer still completes with done, and no further grant is made.
  - Required: rst_n low during ISSUE gives cmd_valid=0 and busy=0 the next cycle.
